// File: rtl/dac_spi_writer.sv
// dac_spi_writer: DAC power-up sequencing plus valid/ready to 24-bit SPI frame serializer with LDAC strobe.
module dac_spi_writer #(
  parameter int CLK_DIV = 2,
  parameter int RST_CYCLES = 16,
  parameter int INIT_WAIT = 64,
  parameter int SYNC_GAP = 4,
  parameter int LDAC_W = 2,
  parameter logic [1:0] MODE = 2'b11
) (
  input  logic        sys_clk,
  input  logic        n_rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        ldac_req,
  output logic        busy,
  output logic        init_done,
  output logic        sdi,
  output logic        sclk,
  output logic        n_sync,
  output logic        n_reset,
  output logic        n_ldac
);
  localparam int CW = 16;
  typedef enum logic [2:0] {RST_PULSE, RST_WAIT, IDLE, SHIFT, GAP, LDAC} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [4:0] bit_cnt;
  logic [22:0] sr;
  logic pend;
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= RST_PULSE;
      cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      pend <= 1'b0;
      sdi <= 1'b0;
      sclk <= 1'b1;
      n_sync <= 1'b1;
      n_reset <= 1'b0;
      n_ldac <= 1'b1;
      wr_ready <= 1'b0;
      busy <= 1'b0;
      init_done <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (ldac_req) pend <= 1'b1;
      case (state)
        RST_PULSE: if (cnt == CW'(RST_CYCLES - 1)) begin
          n_reset <= 1'b1;
          cnt <= '0;
          state <= RST_WAIT;
        end
        RST_WAIT: if (cnt == CW'(INIT_WAIT - 1)) begin
          init_done <= 1'b1;
          wr_ready <= 1'b1;
          state <= IDLE;
        end
        IDLE: begin
          cnt <= '0;
          if (wr_valid) begin
            // bit 23 goes straight to sdi; sr holds the remaining 23 bits
            sr <= {MODE[0], wr_addr, wr_data};
            sdi <= MODE[1];
            n_sync <= 1'b0;
            wr_ready <= 1'b0;
            busy <= 1'b1;
            bit_cnt <= '0;
            state <= SHIFT;
          end else if (pend) begin
            n_ldac <= 1'b0;
            wr_ready <= 1'b0;
            busy <= 1'b1;
            state <= LDAC;
          end
        end
        SHIFT: begin
          if (cnt == CW'(CLK_DIV - 1)) sclk <= 1'b0;
          if (cnt == CW'(2 * CLK_DIV - 1)) begin
            cnt <= '0;
            sclk <= 1'b1;
            if (bit_cnt == 5'd23) begin
              n_sync <= 1'b1;
              state <= GAP;
            end else begin
              sdi <= sr[22];
              sr <= sr << 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: if (cnt == CW'(SYNC_GAP - 1)) begin
          cnt <= '0;
          if (pend) begin
            n_ldac <= 1'b0;
            state <= LDAC;
          end else begin
            wr_ready <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        LDAC: if (cnt == CW'(LDAC_W - 1)) begin
          n_ldac <= 1'b1;
          pend <= ldac_req;
          wr_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_writer.sv
// tb_dac_spi_writer: vector table, corner sequences and random writes against a frame-level model.
module tb_dac_spi_writer;
  logic clk = 0, n_rst = 0, wr_valid = 0, ldac_req = 0, wr_valid1 = 0;
  logic [5:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic wr_ready, busy, init_done, sdi, sclk, n_sync, n_reset, n_ldac;
  logic wr_ready1, busy1, init_done1, sdi1, sclk1, n_sync1, n_reset1, n_ldac1;
  logic [7:0] outvec;
  int cyc = 0, n_chk = 0, n_fail = 0, overlap = 0;

  typedef struct {logic [5:0] a; logic [15:0] d; logic [23:0] f;} vec_t;
  typedef struct {logic [23:0] bits; int nbits; int fall; int rise; int sfall;} frm_t;
  typedef struct {int start; int w;} pls_t;
  vec_t tbl[5];
  frm_t q_frm[$];
  pls_t q_pls[$];

  dac_spi_writer u_dut (
    .sys_clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .ldac_req(ldac_req), .busy(busy),
    .init_done(init_done), .sdi(sdi), .sclk(sclk), .n_sync(n_sync),
    .n_reset(n_reset), .n_ldac(n_ldac)
  );

  dac_spi_writer #(.CLK_DIV(1)) u_d1 (
    .sys_clk(clk), .n_rst(n_rst), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
    .wr_addr(wr_addr), .wr_data(wr_data), .ldac_req(1'b0), .busy(busy1),
    .init_done(init_done1), .sdi(sdi1), .sclk(sclk1), .n_sync(n_sync1),
    .n_reset(n_reset1), .n_ldac(n_ldac1)
  );

  assign outvec = {sdi, sclk, n_sync, n_reset, n_ldac, wr_ready, busy, init_done};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: rebuilds frames from sdi at each sclk fall while n_sync is low
  logic p_sclk = 1, p_nsync = 1, p_nldac = 1;
  logic [23:0] m_bits = '0;
  int m_n = 0, m_fall = 0, m_sfall = 0, l_start = 0;
  always @(negedge clk) begin
    if (n_rst) begin
      if (p_nsync && !n_sync) begin m_n = 0; m_bits = '0; m_fall = cyc; m_sfall = -1; end
      if (!n_sync && p_sclk && !sclk) begin
        m_bits = {m_bits[22:0], sdi};
        if (m_n == 0) m_sfall = cyc;
        m_n++;
      end
      if (!p_nsync && n_sync) q_frm.push_back('{m_bits, m_n, m_fall, cyc, m_sfall});
      if (p_nldac && !n_ldac) l_start = cyc;
      if (!p_nldac && n_ldac) q_pls.push_back('{l_start, cyc - l_start});
      if (!n_ldac && !n_sync) overlap++;
    end
    p_sclk = sclk; p_nsync = n_sync; p_nldac = n_ldac;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic send(input logic [5:0] a, input logic [15:0] d, input bit hold, input bit ld, output int acc);
    int t = 0;
    wr_valid = 1; wr_addr = a; wr_data = d; ldac_req = ld;
    while (!wr_ready && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) timeout("send");
    acc = cyc;
    @(negedge clk);
    ldac_req = 0;
    if (!hold) wr_valid = 0;
    wr_addr = 6'($urandom);
    wr_data = 16'($urandom);
  endtask

  task automatic wait_ready(output int r);
    int t = 0;
    while (!wr_ready && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) timeout("wait_ready");
    r = cyc;
  endtask

  task automatic init_seq(input int ldac_at);
    int nr = -1, id = -1, id1 = -1, lf = -1, lw = 0;
    logic rdy = 0;
    @(negedge clk);
    n_rst = 1;
    chk("reset_vals", outvec, 8'b01101000);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      ldac_req = (c == ldac_at);
      if (n_reset && nr < 0) nr = c;
      if (init_done && id < 0) begin id = c; rdy = wr_ready; end
      if (init_done1 && id1 < 0) id1 = c;
      if (!n_ldac) begin if (lf < 0) lf = c; lw++; end
    end
    ldac_req = 0;
    chk("n_reset_rise", nr, 16);
    chk("init_done_rise", id, 80);
    chk("init_ready", rdy, 1);
    chk("d1_init_done_rise", id1, 80);
    chk("init_ldac_width", lw, ldac_at > 0 ? 2 : 0);
    if (ldac_at > 0) chk("init_ldac_start", lf, 81);
  endtask

  task automatic single(input vec_t v, input bit ld);
    int acc, r;
    frm_t f;
    q_frm.delete(); q_pls.delete();
    send(v.a, v.d, 0, ld, acc);
    chk("frame_start", {n_sync, sclk, sdi, busy}, 4'b0111);
    wait_ready(r);
    @(negedge clk);
    chk("ready_latency", r - acc, ld ? 103 : 101);
    chk("frame_count", q_frm.size(), 1);
    if (q_frm.size() > 0) begin
      f = q_frm.pop_front();
      chk("frame_bits", f.bits, v.f);
      chk("frame_nbits", f.nbits, 24);
      chk("nsync_fall", f.fall - acc, 1);
      chk("nsync_low", f.rise - f.fall, 96);
      chk("first_sclk_fall", f.sfall - acc, 3);
    end
    chk("ldac_pulses", q_pls.size(), ld ? 1 : 0);
    if (ld && q_pls.size() > 0) begin
      chk("ldac_start", q_pls[0].start - acc, 101);
      chk("ldac_width", q_pls[0].w, 2);
    end
  endtask

  task automatic back_to_back();
    int a1, a2, r;
    q_frm.delete();
    send(tbl[1].a, tbl[1].d, 1, 0, a1);
    send(tbl[2].a, tbl[2].d, 0, 0, a2);
    wait_ready(r);
    @(negedge clk);
    chk("b2b_accept_spacing", a2 - a1, 101);
    chk("b2b_frame_count", q_frm.size(), 2);
    if (q_frm.size() == 2) begin
      chk("b2b_frame0", q_frm[0].bits, tbl[1].f);
      chk("b2b_frame1", q_frm[1].bits, tbl[2].f);
      chk("b2b_sync_gap", q_frm[1].fall - q_frm[0].rise, 5);
    end
  endtask

  task automatic ldac_mid_frame();
    int acc, r;
    q_frm.delete(); q_pls.delete();
    send(tbl[3].a, tbl[3].d, 0, 0, acc);
    repeat (20) @(negedge clk);
    ldac_req = 1; @(negedge clk); ldac_req = 0;
    while (cyc < acc + 90) @(negedge clk);
    ldac_req = 1; @(negedge clk); ldac_req = 0;
    wait_ready(r);
    @(negedge clk);
    chk("mid_ldac_ready", r - acc, 103);
    chk("mid_ldac_pulses", q_pls.size(), 1);
    if (q_pls.size() > 0) begin
      chk("mid_ldac_start", q_pls[0].start - acc, 101);
      chk("mid_ldac_width", q_pls[0].w, 2);
    end
    chk("mid_ldac_frame", q_frm.size() > 0 ? q_frm[0].bits : 24'h0, tbl[3].f);
  endtask

  task automatic rand_test();
    logic [23:0] exp_q[$];
    int nreq = 0, r;
    bit ok;
    q_frm.delete(); q_pls.delete(); overlap = 0;
    for (int i = 0; i < 16; i++) begin
      logic [5:0] a;
      logic [15:0] d;
      int acc;
      a = 6'($urandom);
      d = 16'($urandom);
      exp_q.push_back({2'b11, a, d});
      send(a, d, 0, 0, acc);
      if (i == 0 || $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 120)) @(negedge clk);
        ldac_req = 1; @(negedge clk); ldac_req = 0;
        nreq++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_ready(r);
    repeat (10) @(negedge clk);
    chk("rand_frame_count", q_frm.size(), 16);
    for (int i = 0; i < q_frm.size() && i < 16; i++) begin
      chk("rand_frame_bits", q_frm[i].bits, exp_q[i]);
      chk("rand_nsync_low", q_frm[i].rise - q_frm[i].fall, 96);
      if (i > 0) chk("rand_gap_min", (q_frm[i].fall - q_frm[i-1].rise) >= 5, 1);
    end
    foreach (q_pls[i]) chk("rand_ldac_width", q_pls[i].w, 2);
    ok = q_pls.size() >= 1 && q_pls.size() <= nreq;
    chk("rand_ldac_count", ok, 1);
    chk("rand_ldac_overlap", overlap, 0);
  endtask

  task automatic reset_mid_frame();
    int acc;
    q_frm.delete();
    send(tbl[0].a, tbl[0].d, 0, 0, acc);
    while (cyc < acc + 41) @(negedge clk);
    #2 n_rst = 0;
    #1 chk("async_reset_vals", outvec, 8'b01101000);
    repeat (2) @(negedge clk);
    chk("aborted_frame", q_frm.size(), 0);
    init_seq(0);
  endtask

  task automatic d1_test();
    int lo = 0, nb = 0, t = 0;
    logic [23:0] bits = '0;
    logic p = 1;
    wr_addr = 6'h05; wr_data = 16'hA5C3; wr_valid1 = 1;
    while (!wr_ready1 && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) timeout("d1_send");
    @(negedge clk);
    wr_valid1 = 0;
    for (int c = 0; c < 80; c++) begin
      if (!n_sync1) begin
        lo++;
        if (p && !sclk1) begin bits = {bits[22:0], sdi1}; nb++; end
      end
      p = sclk1;
      @(negedge clk);
    end
    chk("d1_nsync_low", lo, 48);
    chk("d1_nbits", nb, 24);
    chk("d1_frame", bits, 24'hC5A5C3);
  endtask

  initial begin
    tbl[0] = '{6'h05, 16'hA5C3, 24'hC5A5C3};
    tbl[1] = '{6'h00, 16'h0000, 24'hC00000};
    tbl[2] = '{6'h3F, 16'hFFFF, 24'hFFFFFF};
    tbl[3] = '{6'h2A, 16'h1234, 24'hEA1234};
    tbl[4] = '{6'h15, 16'h8001, 24'hD58001};
    repeat (3) @(negedge clk);
    init_seq(40);
    for (int i = 0; i < 5; i++) single(tbl[i], 0);
    back_to_back();
    ldac_mid_frame();
    single(tbl[4], 1);
    rand_test();
    reset_mid_frame();
    d1_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
